// File: rtl/interp_ctrl.sv
// interp_ctrl: sequences the NB-IoT channel-estimation interpolation datapath
//   (one preload step, then NUM_PAIRS output steps of two subcarriers each).
// Latency: start at t -> PRE at t+1 -> first out_vld at t+2 -> done at t+7 without stalls.
// Backpressure: eq_ready=0 in OUT freezes state, pair counter and every output;
//   PRE never stalls.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, eq_ready   pilot-set-valid pulse, equalizer accept
//   busy, done        sequence active, last pair accepted (gated by eq_ready)
//   s1a/s1b/s2a/s2b   adder operand selects
//   s_h1/s_h2         output mux selects
//   en_reg_*          datapath register enables (PRE only)
//   out_vld, sc_idx   output pair valid, subcarrier index on h_eqlz_1
//   err               sticky protocol error, built only with INTERP_CTRL_ERR_EN
module interp_ctrl #(
  parameter int NUM_PAIRS = 6,
  parameter int CNT_W     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       eq_ready,
  output logic       busy,
  output logic [1:0] s1a,
  output logic [1:0] s1b,
  output logic [1:0] s2a,
  output logic [1:0] s2b,
  output logic [1:0] s_h1,
  output logic [1:0] s_h2,
  output logic       en_reg_h6,
  output logic       en_reg_2h6,
  output logic       en_reg_5h9,
  output logic       out_vld,
  output logic [3:0] sc_idx,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PAIRS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_acc;

  // Final pair handed to the equalizer this cycle; also the only cycle in
  // which a new start is accepted while busy (back-to-back sets).
  assign last_acc = (state_q == ST_OUT) && eq_ready && (cnt_q == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_PRE;
      end
      ST_PRE: begin
        state_d = ST_OUT;
        cnt_d   = '0;
      end
      ST_OUT: begin
        if (eq_ready) begin
          if (cnt_q == LAST_CNT) begin
            state_d = start ? ST_PRE : ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore output decode of state and pair counter
  always_comb begin
    s1a        = 2'd0;
    s1b        = 2'd0;
    s2a        = 2'd0;
    s2b        = 2'd0;
    s_h1       = 2'd0;
    s_h2       = 2'd0;
    en_reg_h6  = 1'b0;
    en_reg_2h6 = 1'b0;
    en_reg_5h9 = 1'b0;
    out_vld    = 1'b0;
    sc_idx     = 4'd0;
    case (state_q)
      ST_PRE: begin
        // Load h6, 2*h6 and 5*h9 products used by the interior/extrapolated pairs.
        s1a        = 2'd1;
        s1b        = 2'd2;
        s2a        = 2'd2;
        s2b        = 2'd1;
        en_reg_h6  = 1'b1;
        en_reg_2h6 = 1'b1;
        en_reg_5h9 = 1'b1;
      end
      ST_OUT: begin
        out_vld = 1'b1;
        sc_idx  = 4'({cnt_q, 1'b0});
        case (cnt_q)
          3'd0: begin
            s_h2 = 2'd2;
          end
          3'd1: begin
            s_h1 = 2'd2;
          end
          3'd2: begin
            s1a = 2'd2; s1b = 2'd1; s2a = 2'd1; s2b = 2'd2;
            s_h1 = 2'd3; s_h2 = 2'd1;
          end
          3'd3: begin
            s1a = 2'd2; s1b = 2'd1; s2a = 2'd1; s2b = 2'd2;
            s_h1 = 2'd1; s_h2 = 2'd3;
          end
          3'd4: begin
            s1a = 2'd3; s1b = 2'd3; s2a = 2'd3; s2b = 2'd3;
            s_h1 = 2'd3; s_h2 = 2'd1;
          end
          3'd5: begin
            // Subcarriers 10/11 lie beyond h9 and are extrapolated.
            s1a = 2'd3; s1b = 2'd3; s2a = 2'd0; s2b = 2'd3;
            s_h1 = 2'd2; s_h2 = 2'd3;
          end
          default: begin
            s1a = 2'd0;
          end
        endcase
      end
      default: begin
        out_vld = 1'b0;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign done = last_acc;

`ifdef INTERP_CTRL_ERR_EN
  logic err_q, err_d;

  // A start while busy is a protocol violation unless it lands on the
  // last-pair accept cycle, where it chains the next set.
  always_comb begin
    err_d = err_q;
    if (start && busy && !last_acc) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_interp_ctrl.sv
// Testbench for interp_ctrl: scoreboard of expected control steps per pilot set.
module tb_interp_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, eq_ready;
  logic       busy, out_vld, done, err;
  logic [1:0] s1a, s1b, s2a, s2b, s_h1, s_h2;
  logic       en_reg_h6, en_reg_2h6, en_reg_5h9;
  logic [3:0] sc_idx;

  interp_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .eq_ready(eq_ready),
    .busy(busy), .s1a(s1a), .s1b(s1b), .s2a(s2a), .s2b(s2b),
    .s_h1(s_h1), .s_h2(s_h2),
    .en_reg_h6(en_reg_h6), .en_reg_2h6(en_reg_2h6), .en_reg_5h9(en_reg_5h9),
    .out_vld(out_vld), .sc_idx(sc_idx), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // One expected step of a pilot set: the preload, or output pair number cnt.
  typedef struct {
    bit pre;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   exp_err = 1'b0;

  // Control word {s1a,s1b,s2a,s2b,s_h1,s_h2,en_h6,en_2h6,en_5h9} as tabulated.
  function automatic logic [14:0] ref_word(input bit pre, input int c);
    logic [14:0] w;
    if (pre) w = {2'd1, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0, 3'b111};
    else begin
      case (c)
        0:       w = {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 3'b000};
        1:       w = {2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 3'b000};
        2:       w = {2'd2, 2'd1, 2'd1, 2'd2, 2'd3, 2'd1, 3'b000};
        3:       w = {2'd2, 2'd1, 2'd1, 2'd2, 2'd1, 2'd3, 3'b000};
        4:       w = {2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 3'b000};
        default: w = {2'd3, 2'd3, 2'd0, 2'd3, 2'd2, 2'd3, 3'b000};
      endcase
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  // Monitor / scoreboard: compares every cycle at the falling edge, then
  // advances the reference according to the inputs seen in that cycle.
  initial begin
    forever begin
      logic [14:0] ew, gw, es, gs;
      bit          busy_now, last_acc;
      @(negedge clk);
      gw = {s1a, s1b, s2a, s2b, s_h1, s_h2, en_reg_h6, en_reg_2h6, en_reg_5h9};
      gs = {7'd0, busy, out_vld, sc_idx, done, err};
      if (rst) begin
        q.delete();
        exp_err = 1'b0;
        ew = '0;
        es = '0;
      end else if (q.size() == 0) begin
        ew = '0;
        es = {13'd0, 1'b0, exp_err};
      end else begin
        ew = ref_word(q[0].pre, q[0].cnt);
        es = {7'd0, 1'b1, !q[0].pre, (q[0].pre ? 4'd0 : 4'(2 * q[0].cnt)),
              (!q[0].pre && q[0].cnt == 5 && eq_ready), exp_err};
      end
      check("ctrl_word", gw, ew);
      check("status", gs, es);

      if (!rst) begin
        busy_now = (q.size() != 0);
        last_acc = busy_now && !q[0].pre && q[0].cnt == 5 && eq_ready;
`ifdef INTERP_CTRL_ERR_EN
        if (start && busy_now && !last_acc) exp_err = 1'b1;
`endif
        if (busy_now && (q[0].pre || eq_ready)) void'(q.pop_front());
        if (start && (!busy_now || last_acc)) begin
          q.push_back('{pre: 1'b1, cnt: 0});
          for (int i = 0; i < 6; i++) q.push_back('{pre: 1'b0, cnt: i});
        end
      end
    end
  end

  task automatic step(input logic st, input logic er);
    start    = st;
    eq_ready = er;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; eq_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, 1);

    // Single set, no stalls.
    step(1, 1);
    repeat (10) step(0, 1);

    // Three stall cycles at pair 2.
    step(1, 1);
    repeat (3) step(0, 1);
    repeat (3) step(0, 0);
    repeat (8) step(0, 1);

    // Back-to-back: start on the last-pair accept cycle.
    step(1, 1);
    repeat (6) step(0, 1);
    step(1, 1);
    repeat (10) step(0, 1);

    // Stray start at pair 1 is ignored (flags err when the feature is built).
    step(1, 1);
    repeat (2) step(0, 1);
    step(1, 1);
    repeat (8) step(0, 1);

    // Reset while emitting pair 3.
    step(1, 1);
    repeat (4) step(0, 1);
    rst = 1'b1;
    step(0, 1);
    rst = 1'b0;
    repeat (3) step(0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 5) == 0), ($urandom_range(0, 9) < 7));
    repeat (10) step(0, 1);

    // Equalizer never ready: sequence parks on pair 0.
    step(1, 0);
    repeat (20) step(0, 0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
